one_wire_rom_tx: RTL and testbench
==================================

# one_wire_rom_tx

Bit-serial transmitter for the 1-Wire 64-bit ROM code on the responder side: it serializes the 8-bit family code and 48-bit serial number LSB-first and appends the Dallas/Maxim CRC-8, computed on the fly, as the final 8 bits. It is the producing counterpart of the CRC checker on the receive path. It sits between the ROM-ID registers and the 1-Wire slot timing engine, which pulls one bit per read slot through a valid/ready handshake.

## Interface
- `UID_SERIAL_DATA_WIDTH`, 56: number of payload bits (family + serial) sent before the CRC.
- `CRC_WIDTH`, 8: number of CRC bits appended.
- `CRC_POLY_REFL`, 8'h8C: reflected form of x^8+x^5+x^4+1.

- `clk` input 1: sole clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start_tx` input 1: one-cycle request to begin a ROM code transfer; sampled only in IDLE.
- `abort` input 1: returns the block to IDLE from any state (bus reset pulse detected).
- `family_code` input 8: payload bits [7:0]; captured on the accepted `start_tx`.
- `serial_num` input 48: payload bits [55:8]; captured on the accepted `start_tx`.
- `tx_ready` input 1: the slot engine consumes `tx_bit` when `tx_valid & tx_ready`.
- `tx_bit` output 1: current bit to drive on the bus.
- `tx_valid` output 1: `tx_bit` is valid.
- `busy` output 1: high in SEND_DATA and SEND_CRC.
- `tx_done` output 1: one-cycle pulse after the last CRC bit is consumed.
- `crc_out` output 8: running CRC; holds the final CRC after a transfer.

## Operation
- States: IDLE, SEND_DATA, SEND_CRC.
- IDLE to SEND_DATA on `start_tx`:
  - load shift register = {serial_num, family_code};
  - clear crc to 0;
  - set bit counter to UID_SERIAL_DATA_WIDTH−1.
- SEND_DATA: `tx_bit` = shift[0].
  - On each handshake:
    - crc ← (crc>>1) ^ (CRC_POLY_REFL if crc[0]^tx_bit else 0);
    - shift ← shift>>1;
    - counter −1.
  - On the handshake with counter==0: go to SEND_CRC, counter ← CRC_WIDTH−1.
- SEND_CRC: `tx_bit` = crc[0].
  - On each handshake: crc shifts right into a separate output register so that `crc_out` keeps the full final value.
  - Implementation: on entry, copy crc into a crc_tx shift register; `tx_bit` = crc_tx[0].
  - On the handshake with counter==0: go to IDLE and pulse `tx_done`.
- `abort` has priority over every handshake and over `start_tx`:
  - state goes to IDLE; `tx_done` is not pulsed;
  - `crc_out` holds its partial value.
- `start_tx` outside IDLE is ignored. Changes on `family_code`/`serial_num` after capture have no effect.
- Total bits per transfer: UID_SERIAL_DATA_WIDTH + CRC_WIDTH = 64.
- Arithmetic: counter width is clog2 of the larger of the two widths; no wrap.

## Timing
- Reset values:
  - `tx_bit`=0, `tx_valid`=0, `busy`=0, `tx_done`=0, `crc_out`=8'h00;
  - state IDLE.
- `tx_valid` and `busy` rise the cycle after the accepted `start_tx`. The first bit is valid then.
- With `tx_ready` held high, one bit is consumed per cycle: 64 consecutive valid cycles.
- `tx_done` is high the cycle after the 64th handshake, the same cycle `tx_valid`/`busy` fall.
- A new `start_tx` is accepted in the `tx_done` cycle, giving back-to-back transfers with one idle cycle.
- `tx_bit` is stable while `tx_valid & ~tx_ready`. `tx_ready` may deassert arbitrarily.
- `abort` asserted: `tx_valid`/`busy` are low the next cycle.
- `abort` and `start_tx` together in IDLE: stay IDLE.
- `rst_n` low mid-transfer: immediate return to reset values.

## Structure
- Shared package `one_wire_pkg` holds:
  - the ROM code widths (56/8/64);
  - CRC_POLY_REFL;
  - the state enum.
- The CRC checker uses the same package.
- One sub-module is natural: `one_wire_crc8_step`, a combinational next-CRC function of (crc, bit). It is reusable by the checker.

## Test plan
- Maxim reference code: family 8'h02, serial 48'h000000_01B81C, `tx_ready` always high.
  - Required: bits LSB-first of 8'h02, 8'h1C, 8'hB8, 8'h01, 00, 00, 00, then CRC 8'hA2 (10100010 sent as 0,1,0,0,0,1,0,1).
  - `crc_out`=8'hA2; `tx_done` exactly 65 cycles after `start_tx`.
- All-zero payload.
  - Required: 64 zero bits; `crc_out`=8'h00.
- Random `tx_ready` backpressure with the Maxim code.
  - Required: the bitstream is identical to the first scenario; `tx_bit` is stable during stalls.
  - Feeding the 64 bits into the receive CRC checker yields residual 8'h00.
- `abort` after the 20th handshake.
  - Required: `tx_valid`=0 next cycle, no `tx_done`.
  - A following `start_tx` produces a full correct 64-bit transfer.
- `start_tx` pulsed again at bit 30.
  - Required: ignored; the transfer completes unchanged.
  - `start_tx` in the `tx_done` cycle starts the next transfer.
- `rst_n` asserted at bit 60.
  - Required: all outputs at reset values asynchronously; IDLE after release.

Source files
------------

// File: rtl/one_wire_pkg.sv
// Shared definitions for the 1-Wire ROM code path: widths, CRC-8 polynomial,
// transmitter state encoding and the single-bit CRC-8 update.
package one_wire_pkg;

    localparam int UID_SERIAL_DATA_WIDTH = 56;
    localparam int CRC_WIDTH             = 8;
    localparam int ROM_CODE_WIDTH        = UID_SERIAL_DATA_WIDTH + CRC_WIDTH;
    localparam logic [CRC_WIDTH-1:0] CRC_POLY_REFL = 8'h8C;

    localparam int CNT_WIDTH = $clog2((UID_SERIAL_DATA_WIDTH > CRC_WIDTH) ?
                                      UID_SERIAL_DATA_WIDTH : CRC_WIDTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND_DATA = 2'd1,
        SEND_CRC  = 2'd2
    } ow_state_e;

    // Dallas/Maxim CRC-8, LSB-first: feedback is the outgoing CRC bit xor the data bit.
    function automatic logic [CRC_WIDTH-1:0] crc8_step(input logic [CRC_WIDTH-1:0] crc,
                                                       input logic data_bit);
        logic [CRC_WIDTH-1:0] shifted;
        shifted = crc >> 1;
        if (crc[0] ^ data_bit) begin
            crc8_step = shifted ^ CRC_POLY_REFL;
        end else begin
            crc8_step = shifted;
        end
    endfunction

endpackage

// File: rtl/one_wire_crc8_step.sv
// Combinational one-bit CRC-8 update, shared by the ROM transmitter and the
// receive-side CRC checker.
module one_wire_crc8_step
    import one_wire_pkg::*;
(
    input  logic [CRC_WIDTH-1:0] crc,
    input  logic                 data_bit,
    output logic [CRC_WIDTH-1:0] crc_next
);

    assign crc_next = crc8_step(crc, data_bit);

endmodule

// File: rtl/one_wire_rom_tx.sv
// 1-Wire responder ROM code serializer: 56 payload bits LSB-first followed by
// the on-the-fly CRC-8, one bit per valid/ready handshake.
module one_wire_rom_tx
    import one_wire_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_tx,
    input  logic                  abort,
    input  logic [7:0]            family_code,
    input  logic [47:0]           serial_num,
    input  logic                  tx_ready,
    output logic                  tx_bit,
    output logic                  tx_valid,
    output logic                  busy,
    output logic                  tx_done,
    output logic [CRC_WIDTH-1:0]  crc_out
);

    ow_state_e                        state_r, state_s;
    logic [UID_SERIAL_DATA_WIDTH-1:0] shift_r, shift_s;
    logic [CRC_WIDTH-1:0]             crc_r, crc_s;
    logic [CRC_WIDTH-1:0]             crc_tx_r, crc_tx_s;
    logic [CRC_WIDTH-1:0]             crc_step_s;
    logic [CNT_WIDTH-1:0]             cnt_r, cnt_s;
    logic                             active_r, active_s;
    logic                             bit_r, bit_s;
    logic                             done_r, done_s;
    logic                             handshake_s;

    one_wire_crc8_step u_crc8_step (
        .crc      (crc_r),
        .data_bit (shift_r[0]),
        .crc_next (crc_step_s)
    );

    assign handshake_s = active_r & tx_ready;

    // Next-state and datapath update; abort overrides every handshake and start request.
    always_comb begin
        state_s  = state_r;
        shift_s  = shift_r;
        crc_s    = crc_r;
        crc_tx_s = crc_tx_r;
        cnt_s    = cnt_r;
        done_s   = 1'b0;
        if (abort) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_tx) begin
                        state_s = SEND_DATA;
                        shift_s = {serial_num, family_code};
                        crc_s   = {CRC_WIDTH{1'b0}};
                        cnt_s   = CNT_WIDTH'(UID_SERIAL_DATA_WIDTH - 1);
                    end else begin
                        state_s = IDLE;
                    end
                end
                SEND_DATA: begin
                    if (handshake_s) begin
                        crc_s   = crc_step_s;
                        shift_s = shift_r >> 1;
                        if (cnt_r == {CNT_WIDTH{1'b0}}) begin
                            // crc_r keeps the final value for crc_out; crc_tx is the copy shifted out
                            state_s  = SEND_CRC;
                            crc_tx_s = crc_step_s;
                            cnt_s    = CNT_WIDTH'(CRC_WIDTH - 1);
                        end else begin
                            cnt_s = cnt_r - CNT_WIDTH'(1);
                        end
                    end else begin
                        state_s = SEND_DATA;
                    end
                end
                SEND_CRC: begin
                    if (handshake_s) begin
                        crc_tx_s = crc_tx_r >> 1;
                        if (cnt_r == {CNT_WIDTH{1'b0}}) begin
                            state_s = IDLE;
                            done_s  = 1'b1;
                        end else begin
                            cnt_s = cnt_r - CNT_WIDTH'(1);
                        end
                    end else begin
                        state_s = SEND_CRC;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // Output bit and valid are precomputed from next state so all outputs come straight from flops.
    always_comb begin
        active_s = 1'b0;
        bit_s    = 1'b0;
        case (state_s)
            SEND_DATA: begin
                active_s = 1'b1;
                bit_s    = shift_s[0];
            end
            SEND_CRC: begin
                active_s = 1'b1;
                bit_s    = crc_tx_s[0];
            end
            default: begin
                active_s = 1'b0;
                bit_s    = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            shift_r  <= {UID_SERIAL_DATA_WIDTH{1'b0}};
            crc_r    <= {CRC_WIDTH{1'b0}};
            crc_tx_r <= {CRC_WIDTH{1'b0}};
            cnt_r    <= {CNT_WIDTH{1'b0}};
            active_r <= 1'b0;
            bit_r    <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            shift_r  <= shift_s;
            crc_r    <= crc_s;
            crc_tx_r <= crc_tx_s;
            cnt_r    <= cnt_s;
            active_r <= active_s;
            bit_r    <= bit_s;
            done_r   <= done_s;
        end
    end

    assign tx_bit   = bit_r;
    assign tx_valid = active_r;
    assign busy     = active_r;
    assign tx_done  = done_r;
    assign crc_out  = crc_r;

endmodule

// File: tb/tb_one_wire_rom_tx.sv
// Self-checking bench for one_wire_rom_tx: table of ROM-code transfers with
// backpressure/abort/restart options, expected bitstream held in a scoreboard queue.
module tb_one_wire_rom_tx;

    logic        clk;
    logic        rst_n;
    logic        start_tx;
    logic        abort;
    logic [7:0]  family_code;
    logic [47:0] serial_num;
    logic        tx_ready;
    logic        tx_bit;
    logic        tx_valid;
    logic        busy;
    logic        tx_done;
    logic [7:0]  crc_out;

    int checks;
    int errors;
    logic sbq[$];

    typedef struct {
        string       name;
        logic [7:0]  fam;
        logic [47:0] ser;
        int          ready_pct;
        int          abort_at;
        int          restart_at;
        bit          use_const_crc;
        logic [7:0]  const_crc;
    } vec_t;

    vec_t vecs[8];

    one_wire_rom_tx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_tx    (start_tx),
        .abort       (abort),
        .family_code (family_code),
        .serial_num  (serial_num),
        .tx_ready    (tx_ready),
        .tx_bit      (tx_bit),
        .tx_valid    (tx_valid),
        .busy        (busy),
        .tx_done     (tx_done),
        .crc_out     (crc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference Dallas/Maxim CRC-8 over the first n bits of v, LSB-first.
    function automatic logic [7:0] crc_model(input logic [63:0] v, input int n);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 0; i < n; i++) begin
            fb = c[0] ^ v[i];
            c  = c >> 1;
            if (fb) c = c ^ 8'h8C;
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input vec_t v);
        logic [63:0] payload;
        logic [63:0] rx;
        logic [7:0]  exp_crc;
        int          hs;
        int          ticks;
        bit          aborted;
        bit          done_seen;
        bit          stalled;
        logic        stall_bit;

        payload = {8'h00, v.ser, v.fam};
        exp_crc = crc_model(payload, 56);
        for (int i = 0; i < 56; i++) sbq.push_back(payload[i]);
        for (int i = 0; i < 8; i++) sbq.push_back(exp_crc[i]);

        family_code = v.fam;
        serial_num  = v.ser;
        start_tx    = 1'b1;
        tx_ready    = 1'b0;
        tick();
        ticks = 1;
        start_tx    = 1'b0;
        family_code = ~v.fam;
        serial_num  = ~v.ser;
        chk({v.name, " valid after start"}, {63'd0, tx_valid}, 64'd1);
        chk({v.name, " busy after start"}, {63'd0, busy}, 64'd1);

        rx        = 64'd0;
        hs        = 0;
        aborted   = 1'b0;
        done_seen = 1'b0;
        stalled   = 1'b0;
        stall_bit = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            tx_ready = ($urandom_range(99) < v.ready_pct);
            abort    = (hs == v.abort_at);
            start_tx = (hs == v.restart_at);
            if (v.restart_at >= 0 && hs == v.restart_at) begin
                family_code = 8'hFF;
                serial_num  = 48'hFFFF_FFFF_FFFF;
            end
            #2;
            if (stalled && tx_valid) chk({v.name, " stall stable"}, {63'd0, tx_bit}, {63'd0, stall_bit});
            stalled   = tx_valid && !tx_ready;
            stall_bit = tx_bit;
            if (tx_valid && tx_ready && !abort) begin
                if (sbq.size() == 0) begin
                    chk({v.name, " extra bit"}, 64'd1, 64'd0);
                end else begin
                    chk($sformatf("%s bit%0d", v.name, hs), {63'd0, tx_bit}, {63'd0, sbq.pop_front()});
                end
                if (hs < 64) rx[hs] = tx_bit;
                hs++;
            end
            aborted = abort;
            tick();
            ticks++;
            start_tx = 1'b0;
            abort    = 1'b0;
            if (aborted) break;
            if (tx_done) begin
                done_seen = 1'b1;
                break;
            end
        end
        tx_ready = 1'b0;

        if (aborted) begin
            chk({v.name, " valid after abort"}, {63'd0, tx_valid}, 64'd0);
            chk({v.name, " busy after abort"}, {63'd0, busy}, 64'd0);
            chk({v.name, " no done on abort"}, {63'd0, tx_done}, 64'd0);
            chk({v.name, " partial crc"}, {56'd0, crc_out}, {56'd0, crc_model(payload, v.abort_at)});
            sbq.delete();
        end else begin
            chk({v.name, " done seen"}, {63'd0, done_seen}, 64'd1);
            chk({v.name, " bits consumed"}, 64'(hs), 64'd64);
            chk({v.name, " valid low at done"}, {63'd0, tx_valid}, 64'd0);
            chk({v.name, " crc_out"}, {56'd0, crc_out},
                {56'd0, v.use_const_crc ? v.const_crc : exp_crc});
            chk({v.name, " residual"}, {56'd0, crc_model(rx, 64)}, 64'd0);
            chk({v.name, " queue empty"}, 64'(sbq.size()), 64'd0);
            if (v.ready_pct >= 100) chk({v.name, " done latency"}, 64'(ticks), 64'd65);
            sbq.delete();
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        start_tx    = 1'b0;
        abort       = 1'b0;
        tx_ready    = 1'b0;
        family_code = 8'h00;
        serial_num  = 48'h0;

        vecs[0] = '{"maxim",      8'h02, 48'h0000_0001_B81C, 100, -1, -1, 1'b1, 8'hA2};
        vecs[1] = '{"zero",       8'h00, 48'h0000_0000_0000, 100, -1, -1, 1'b1, 8'h00};
        vecs[2] = '{"maxim_bp",   8'h02, 48'h0000_0001_B81C,  50, -1, -1, 1'b1, 8'hA2};
        vecs[3] = '{"abort20",    8'h02, 48'h0000_0001_B81C, 100, 20, -1, 1'b0, 8'h00};
        vecs[4] = '{"post_abort", 8'h02, 48'h0000_0001_B81C,  70, -1, -1, 1'b1, 8'hA2};
        vecs[5] = '{"restart30",  8'hA5, 48'h1234_5678_9ABC, 100, -1, 30, 1'b0, 8'h00};
        vecs[6] = '{"rand_bp",    8'h28, 48'hFEDC_BA98_7654,  40, -1, -1, 1'b0, 8'h00};
        vecs[7] = '{"b2b_maxim",  8'h02, 48'h0000_0001_B81C, 100, -1, -1, 1'b1, 8'hA2};

        #2;
        chk("reset tx_bit", {63'd0, tx_bit}, 64'd0);
        chk("reset tx_valid", {63'd0, tx_valid}, 64'd0);
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset tx_done", {63'd0, tx_done}, 64'd0);
        chk("reset crc_out", {56'd0, crc_out}, 64'd0);
        #21;
        rst_n = 1'b1;
        tick();

        // abort together with start in IDLE keeps the block idle
        start_tx = 1'b1;
        abort    = 1'b1;
        tick();
        start_tx = 1'b0;
        abort    = 1'b0;
        chk("abort+start idle", {63'd0, tx_valid}, 64'd0);

        // entries run back-to-back: each start lands in the previous tx_done cycle
        for (int i = 0; i < 8; i++) send(vecs[i]);

        // asynchronous reset at bit 60
        family_code = 8'h02;
        serial_num  = 48'h0000_0001_B81C;
        start_tx    = 1'b1;
        tick();
        start_tx = 1'b0;
        tx_ready = 1'b1;
        for (int i = 0; i < 60; i++) tick();
        chk("pre-reset busy", {63'd0, busy}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst tx_bit", {63'd0, tx_bit}, 64'd0);
        chk("async rst tx_valid", {63'd0, tx_valid}, 64'd0);
        chk("async rst busy", {63'd0, busy}, 64'd0);
        chk("async rst tx_done", {63'd0, tx_done}, 64'd0);
        chk("async rst crc_out", {56'd0, crc_out}, 64'd0);
        #10;
        rst_n    = 1'b1;
        tick();
        tick();
        chk("post-reset idle", {63'd0, tx_valid}, 64'd0);
        chk("post-reset done", {63'd0, tx_done}, 64'd0);
        tx_ready = 1'b0;
        send(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
